imm_encoder: RTL
================

// Module: imm_encoder
// PURPOSE
//   Inverse of the immediate extender: packs a 32-bit signed immediate into the
//   RISC-V I/S/B/J immediate fields of a partially built instruction word.
//   Checks that the immediate is in range and aligned. Streaming valid/ready
//   block with a 2-stage pipeline and saturating ok/error statistics counters.
//   Used by the boot/test-program generator path that writes instruction memory.
// PARAMETERS
//   CNT_W   16   width of cnt_ok / cnt_err statistics counters (saturating)
// PORTS
//   clk          in   1      system clock, all state on rising edge
//   resetn       in   1      asynchronous, active-low reset
//   in_valid     in   1      input word offered
//   in_ready     out  1      encoder accepts input this cycle
//   in_imm_type  in   2      `IMM_TYPE_I/S/B/J code (constants.v)
//   in_imm       in   32     signed immediate value (byte offset for B/J)
//   in_base      in   32     instruction with opcode/rd/rs/funct set; imm bits ignored
//   out_valid    out  1      encoded word available
//   out_ready    in   1      consumer takes word this cycle
//   out_instr    out  32     encoded instruction
//   out_err      out  1      immediate out of range / misaligned for this word
//   cnt_clr      in   1      synchronous clear of both counters
//   cnt_ok       out  CNT_W  words handed out with out_err=0
//   cnt_err      out  CNT_W  words handed out with out_err=1
// BEHAVIOUR
//   - Reset (async, resetn=0): s1/s2 valid=0, out_valid=0, out_instr=0,
//     out_err=0, cnt_ok=cnt_err=0. Pipeline contents discarded mid-operation.
//   - Handshake: transfer when valid&&ready. in_valid/data held until accepted.
//   - Stage 1 registers packed word + err; stage 2 is the output register.
//     Accept-to-out_valid latency 2 cycles; throughput 1 word/cycle.
//   - s2 loads when !s2_v || out_ready; s1 loads when !s1_v || s1 advances.
//     in_ready = !s1_v || !s2_v || out_ready (combinational from out_ready).
//   - Order preserved; no word dropped or duplicated under any backpressure.
//   - Range rules (err=1 if violated):
//       I,S: in_imm[31:11] all equal.  B: in_imm[31:12] all equal, in_imm[0]=0.
//       J: in_imm[31:20] all equal, in_imm[0]=0.
//   - Field masks: I [31:20]; S,B [31:25]+[11:7]; J [31:12].
//     out_instr = (in_base & ~mask) | packed; packing exactly inverts immext:
//       I {imm[11:0]}; S {imm[11:5]},{imm[4:0]};
//       B {imm[12],imm[10:5]},{imm[4:1],imm[11]}; J {imm[20],imm[10:1],imm[11],imm[19:12]}.
//   - On err: immediate fields forced to 0, non-imm bits of in_base kept.
//   - Unknown type code impossible (2-bit, all four defined).
//   - Counters increment on out_valid&&out_ready by out_err; saturate at
//     2^CNT_W-1. cnt_clr wins over a same-cycle increment (result 0).
// STRUCTURE
//   - IMM_TYPE_* codes stay in constants.v, shared with immext; add field mask
//     macros there (IMM_MASK_I/S/B/J).
//   - Sub-module imm_pack: combinational range check + packing (type, imm,
//     base -> instr, err); imm_encoder holds pipeline, handshake, counters.
// TESTING
//   - I: base 0x00000013, imm 0xFFFFFFFF -> out_instr 0xFFF00013, err 0, 2 cyc.
//   - S: base 0x0020A023, imm 8 -> 0x0020A423; B: base 0x00000063,
//     imm 0xFFFFFFFC -> 0xFE000EE3; J: base 0x0000006F, imm 0x800 -> 0x0010006F.
//   - Errors: I imm 2048 -> base 0x00000013 returned, err 1; B imm 3 -> err 1;
//     cnt_err=2, cnt_ok unchanged.
//   - Backpressure: out_ready=0, 3 words offered back-to-back -> 2 accepted,
//     in_ready=0; release -> 3 words out in order, no gaps once streaming.
//   - Round-trip: 10k random legal (type,imm) -> immext(out_instr,type)==in_imm;
//     non-imm bits equal in_base.
//   - resetn low mid-stream -> out_valid 0 immediately, counters 0; cnt_clr
//     with handshake same cycle -> counters 0; CNT_W=2 saturates at 3.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-type codes, field masks and range helpers for the immediate encoder.
// Type codes match the ones used by the immediate extender.
package imm_encoder_pkg;

   typedef enum logic [1:0] {
      IMM_TYPE_I = 2'd0,
      IMM_TYPE_S = 2'd1,
      IMM_TYPE_B = 2'd2,
      IMM_TYPE_J = 2'd3
   } imm_type_e;

   localparam logic [31:0] IMM_MASK_I = 32'hFFF0_0000;
   localparam logic [31:0] IMM_MASK_S = 32'hFE00_0F80;
   localparam logic [31:0] IMM_MASK_B = 32'hFE00_0F80;
   localparam logic [31:0] IMM_MASK_J = 32'hFFFF_F000;

   function automatic logic [31:0] imm_mask(input imm_type_e t);
      logic [31:0] m;
      m = IMM_MASK_I;
      case (t)
         IMM_TYPE_I: m = IMM_MASK_I;
         IMM_TYPE_S: m = IMM_MASK_S;
         IMM_TYPE_B: m = IMM_MASK_B;
         IMM_TYPE_J: m = IMM_MASK_J;
         default:    m = IMM_MASK_I;
      endcase
      return m;
   endfunction

   // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed field of lsb+1 bits.
   function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
      logic signed [31:0] s;
      s = $signed(v) >>> lsb;
      return (s == 32'sd0) || (s == -32'sd1);
   endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational range/alignment check and field packing of one immediate into
// an instruction word; the exact inverse of the immediate extender.
import imm_encoder_pkg::*;

module imm_pack (
   input  imm_type_e          imm_type,
   input  logic signed [31:0] imm,
   input  logic        [31:0] base,
   output logic        [31:0] instr,
   output logic               err
);

   logic [31:0] packed_f;
   logic        fits;
   logic        aligned;

   always_comb begin
      packed_f = '0;
      fits     = 1'b0;
      aligned  = 1'b1;
      case (imm_type)
         IMM_TYPE_I: begin
            fits            = sext_fits(imm, 11);
            packed_f[31:20] = imm[11:0];
         end
         IMM_TYPE_S: begin
            fits            = sext_fits(imm, 11);
            packed_f[31:25] = imm[11:5];
            packed_f[11:7]  = imm[4:0];
         end
         IMM_TYPE_B: begin
            fits            = sext_fits(imm, 12);
            aligned         = !imm[0];
            packed_f[31]    = imm[12];
            packed_f[30:25] = imm[10:5];
            packed_f[11:8]  = imm[4:1];
            packed_f[7]     = imm[11];
         end
         IMM_TYPE_J: begin
            fits            = sext_fits(imm, 20);
            aligned         = !imm[0];
            packed_f[31]    = imm[20];
            packed_f[30:21] = imm[10:1];
            packed_f[20]    = imm[11];
            packed_f[19:12] = imm[19:12];
         end
         default: ;
      endcase
   end

   // A rejected immediate leaves its fields zero so the word is still well formed.
   assign err   = !(fits && aligned);
   assign instr = (base & ~imm_mask(imm_type)) | (err ? 32'd0 : packed_f);

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: valid/ready input, two-stage pipeline around
// imm_pack, and saturating ok/error counters on delivered words.
import imm_encoder_pkg::*;

module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic        [1:0]  in_imm_type,
   input  logic signed [31:0] in_imm,
   input  logic        [31:0] in_base,
   output logic               out_valid,
   input  logic               out_ready,
   output logic        [31:0] out_instr,
   output logic               out_err,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   cnt_ok,
   output logic [CNT_W-1:0]   cnt_err
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   imm_type_e   in_type;
   logic [31:0] pack_instr;
   logic        pack_err;

   logic        vld_p1, err_p1;
   logic [31:0] instr_p1;
   logic        vld_p2, err_p2;
   logic [31:0] instr_p2;
   logic        load_p1, load_p2, hs_out;

   assign in_type = imm_type_e'(in_imm_type);

   imm_pack u_pack (
      .imm_type (in_type),
      .imm      (in_imm),
      .base     (in_base),
      .instr    (pack_instr),
      .err      (pack_err)
   );

   assign load_p2  = !vld_p2 || out_ready;
   assign load_p1  = !vld_p1 || load_p2;
   assign in_ready = load_p1;
   assign hs_out   = vld_p2 && out_ready;

   // stage 1: packed word; stage 2: output register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         instr_p1 <= '0;
         vld_p2   <= 1'b0;
         err_p2   <= 1'b0;
         instr_p2 <= '0;
      end else begin
         if (load_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
               instr_p1 <= pack_instr;
               err_p1   <= pack_err;
            end
         end
         if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               instr_p2 <= instr_p1;
               err_p2   <= err_p1;
            end
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_instr = instr_p2;
   assign out_err   = err_p2;

   // Clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_ok  <= '0;
         cnt_err <= '0;
      end else if (cnt_clr) begin
         cnt_ok  <= '0;
         cnt_err <= '0;
      end else if (hs_out) begin
         if (err_p2) cnt_err <= sat_inc(cnt_err);
         else        cnt_ok  <= sat_inc(cnt_ok);
      end
   end

endmodule
